sc_fifo: RTL

Single-clock synchronous FIFO, the single-domain successor to `dc_fifo` for paths where producer and consumer share one clock. It holds the full 2**L2DEPTH entries, where `dc_fifo` holds one fewer. It adds programmable almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It supports both FWFT and standard read modes. Intended for stream buffering between pipeline stages inside one clock domain.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/sc_fifo_ram.sv | 37 +++
 rtl/sc_fifo.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO types: flag bundle and occupancy helper.
// Pointers travel through the helper zero-extended to PTR_MAX bits.
package fifo_pkg;

  localparam int PTR_MAX = 17;

  typedef logic [PTR_MAX-1:0] ptr_t;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  // Callers truncate the result to their own pointer width.
  function automatic ptr_t fifo_level(
    input ptr_t wptr,
    input ptr_t rptr
  );
    return wptr - rptr;
  endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// Simple dual-port storage for sc_fifo.
// Synchronous write, registered synchronous read.
module sc_fifo_ram #(
  parameter int AW = 3,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rd_data_q;
  logic [W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sc_fifo.sv
// Single-clock FIFO with threshold flags, flush, sticky errors
// and optional first-word-fall-through read port.
module sc_fifo #(
  parameter type T        = logic [15:0],
  parameter int  L2DEPTH  = 3,
  parameter bit  FWFT     = 1'b0,
  parameter int  AF_LEVEL = 2**L2DEPTH-1,
  parameter int  AE_LEVEL = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 err_clr,
  input  logic [$bits(T)-1:0]  wr_din,
  input  logic                 wr_write,
  output logic                 wr_full,
  output logic                 wr_almost_full,
  input  logic                 rd_read,
  output logic [$bits(T)-1:0]  rd_dout,
  output logic                 rd_empty,
  output logic                 rd_almost_empty,
  output logic [L2DEPTH:0]     usedw,
  output logic                 overflow,
  output logic                 underflow
);

  import fifo_pkg::*;

  localparam int W     = $bits(T);
  localparam int PW    = L2DEPTH + 1;
  localparam int DEPTH = 2**L2DEPTH;

  if (L2DEPTH < 1 || L2DEPTH > 16) begin : g_bad_depth
    $fatal(1, "sc_fifo: L2DEPTH out of range");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "sc_fifo: AF_LEVEL out of range");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH-1) begin : g_bad_ae
    $fatal(1, "sc_fifo: AE_LEVEL out of range");
  end

  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] AF_THR   = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR   = PW'(AE_LEVEL);

  localparam fifo_flags_t FLAGS_RST = '{
    full: 1'b0, almost_full: 1'b0,
    empty: 1'b1, almost_empty: 1'b1,
    overflow: 1'b0, underflow: 1'b0
  };

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] usedw_q, usedw_d;
  fifo_flags_t   flags_q, flags_d;
  logic [W-1:0]  byp_q, byp_d;
  logic          sel_q, sel_d;

  logic               wr_acc;
  logic               rd_acc;
  logic               ram_rd_en;
  logic [L2DEPTH-1:0] ram_rd_addr;
  logic [W-1:0]       ram_dout;

  always_comb begin
    wr_acc  = wr_write && !flags_q.full && !flush;
    rd_acc  = rd_read && !flags_q.empty && !flush;
    wptr_d  = wptr_q + PW'(wr_acc);
    rptr_d  = rptr_q + PW'(rd_acc);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
    usedw_d = PW'(fifo_level(ptr_t'(wptr_d), ptr_t'(rptr_d)));

    flags_d.full         = usedw_d == FULL_LVL;
    flags_d.almost_full  = usedw_d >= AF_THR;
    flags_d.empty        = usedw_d == '0;
    flags_d.almost_empty = usedw_d <= AE_THR;
    flags_d.overflow  = (flags_q.overflow && !err_clr)
                     || (wr_write && flags_q.full);
    flags_d.underflow = (flags_q.underflow && !err_clr)
                     || (rd_read && flags_q.empty);
    if (flush) begin
      flags_d.overflow  = 1'b0;
      flags_d.underflow = 1'b0;
    end
  end

  // FWFT: the post-edge head is either already in storage or is
  // the word being written this cycle, which must be bypassed.
  always_comb begin
    byp_d       = byp_q;
    sel_d       = sel_q;
    ram_rd_en   = rd_acc;
    ram_rd_addr = rptr_q[L2DEPTH-1:0];
    if (FWFT) begin
      ram_rd_addr = rptr_d[L2DEPTH-1:0];
      ram_rd_en   = !flush && (rptr_d != wptr_q);
      if (wr_acc && (rptr_d == wptr_q)) begin
        byp_d = wr_din;
        sel_d = 1'b1;
      end else if (ram_rd_en) begin
        sel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usedw_q <= '0;
      flags_q <= FLAGS_RST;
      byp_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      usedw_q <= usedw_d;
      flags_q <= flags_d;
      byp_q   <= byp_d;
      sel_q   <= sel_d;
    end
  end

  sc_fifo_ram #(
    .AW(L2DEPTH),
    .W (W)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rstn),
    .wr_en  (wr_acc),
    .wr_addr(wptr_q[L2DEPTH-1:0]),
    .wr_data(wr_din),
    .rd_en  (ram_rd_en),
    .rd_addr(ram_rd_addr),
    .rd_data(ram_dout)
  );

  assign rd_dout         = sel_q ? byp_q : ram_dout;
  assign usedw           = usedw_q;
  assign wr_full         = flags_q.full;
  assign wr_almost_full  = flags_q.almost_full;
  assign rd_empty        = flags_q.empty;
  assign rd_almost_empty = flags_q.almost_empty;
  assign overflow        = flags_q.overflow;
  assign underflow       = flags_q.underflow;

endmodule
